// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit constants: default word width, PC step and FSM state encodings.
// Optional prefetch path is selected by FETCH_PREFETCH_EN (see fetch_unit.sv).
package fetch_unit_pkg;

   localparam int unsigned WORD_SIZE_DEF = 32;
   localparam int unsigned PC_STEP_DEF   = 1;

   localparam logic [1:0] FETCH_IDLE  = 2'd0;
   localparam logic [1:0] FETCH_REQ   = 2'd1;
   localparam logic [1:0] FETCH_HOLD  = 2'd2;
   localparam logic [1:0] FETCH_REDIR = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = FETCH_IDLE,
      StReq   = FETCH_REQ,
      StHold  = FETCH_HOLD,
      StRedir = FETCH_REDIR
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: pointer control, instruction memory read port, redirect and decode handshake.
// master = fetch unit side, slave = pointer/memory/decode side.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
);

   logic [WORD_SIZE-1:0] pc;
   logic [WORD_SIZE-1:0] pc_val;
   logic                 pc_set;
   logic                 pc_update;
   logic                 mem_req;
   logic [WORD_SIZE-1:0] mem_addr;
   logic                 mem_ack;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 redirect;
   logic [WORD_SIZE-1:0] redirect_pc;
   logic [WORD_SIZE-1:0] instr;
   logic [WORD_SIZE-1:0] instr_pc;
   logic                 instr_valid;
   logic                 instr_ready;

   modport master (
      input  pc, mem_ack, mem_rdata, redirect, redirect_pc, instr_ready,
      output pc_val, pc_set, pc_update, mem_req, mem_addr, instr, instr_pc, instr_valid
   );

   modport slave (
      output pc, mem_ack, mem_rdata, redirect, redirect_pc, instr_ready,
      input  pc_val, pc_set, pc_update, mem_req, mem_addr, instr, instr_pc, instr_valid
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry instruction/pc FIFO with synchronous flush; only built when FETCH_PREFETCH_EN is
// defined, so the default build carries no unused module.
`ifdef FETCH_PREFETCH_EN
module fetch_unit_fifo #(
   parameter int unsigned Width = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             do_push, do_pop;

   assign empty    = (cnt_q == 2'd0);
   assign full     = (cnt_q == 2'd2);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];

   // Flush beats a simultaneous pop or push.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Fetch unit: reads the PC pointer, fetches from instruction memory, hands words to decode.
// Define FETCH_PREFETCH_EN for the 2-entry prefetch FIFO (1 instr/cycle); default is 1 per 2.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
   parameter int unsigned PC_STEP   = PC_STEP_DEF
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam logic [WORD_SIZE-1:0] Step = WORD_SIZE'(PC_STEP);

   fetch_state_e state_q, state_d;
   logic         req, redir, fire, xfer;

   assign redir = bus.redirect && !rst;
   // An ack coinciding with a redirect belongs to the abandoned stream.
   assign fire  = req && bus.mem_ack && !redir;
   assign xfer  = bus.instr_valid && bus.instr_ready;

   assign bus.mem_req   = req;
   assign bus.mem_addr  = req ? bus.pc : '0;
   assign bus.pc_set    = redir;
   assign bus.pc_update = fire;
   assign bus.pc_val    = redir ? bus.redirect_pc : (fire ? Step : '0);

`ifdef FETCH_PREFETCH_EN
   logic                   fifo_empty, fifo_full;
   logic [2*WORD_SIZE-1:0] head;

   assign req = (state_q == StReq) && !fifo_full && !rst;

   fetch_unit_fifo #(
      .Width (2 * WORD_SIZE)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redir),
      .push      (fire),
      .push_data ({bus.pc, bus.mem_rdata}),
      .pop       (xfer),
      .pop_data  (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign bus.instr_valid = !fifo_empty && !rst;
   assign bus.instr_pc    = bus.instr_valid ? head[2*WORD_SIZE-1:WORD_SIZE] : '0;
   assign bus.instr       = bus.instr_valid ? head[WORD_SIZE-1:0] : '0;
`else
   logic [WORD_SIZE-1:0] instr_q, instr_pc_q;

   assign req = (state_q == StReq) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else if (fire) begin
         instr_q    <= bus.mem_rdata;
         instr_pc_q <= bus.pc;
      end
   end

   assign bus.instr_valid = (state_q == StHold) && !rst;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StReq;
`ifdef FETCH_PREFETCH_EN
         StReq:   state_d = StReq;
`else
         StReq:   if (fire) state_d = StHold;
`endif
         StHold:  if (xfer) state_d = StReq;
         StRedir: state_d = StReq;
         default: state_d = StIdle;
      endcase
      // REDIR gives the pointer one cycle to load the target before the next fetch.
      if (redir) state_d = StRedir;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed protocol cases, then randomized traffic checked by
// a scoreboard that tracks the architectural fetch stream (pointer and memory modelled here).
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if #(.WORD_SIZE(32)) bus ();

   fetch_unit #(
      .WORD_SIZE (32),
      .PC_STEP   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int xfers  = 0;

   // Program-counter pointer the fetch unit drives.
   logic [31:0] pc_q;
   assign bus.pc = pc_q;
   always @(posedge clk) begin
      if (rst)                pc_q <= 32'h0;
      else if (bus.pc_set)    pc_q <= bus.pc_val;
      else if (bus.pc_update) pc_q <= pc_q + bus.pc_val;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B9) ^ 32'hDEADBEEF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [31:0] redir_q[$];

   // One clock cycle of stimulus; returns at the following negedge for sampling.
   task automatic cyc(input bit r, input bit a, input bit y, input bit d, input logic [31:0] t);
      @(posedge clk);
      #1;
      rst             = r;
      bus.instr_ready = y;
      bus.redirect    = d && !r;
      bus.redirect_pc = d ? t : 32'h0;
      if (d && !r) redir_q.push_back(t);
      #1;
      bus.mem_ack   = a && bus.mem_req && !r;
      bus.mem_rdata = bus.mem_req ? mem_word(bus.mem_addr) : 32'h0;
      @(negedge clk);
   endtask

   // Scoreboard / protocol monitor.
   bit          mon_en = 1'b0;
   logic [31:0] ref_pc = 32'h0;
   logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_rst = 1'b1;
   logic [31:0] p_instr = 32'h0, p_ipc = 32'h0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            check("rst_no_ptr_write", {bus.pc_set, bus.pc_update}, 2'b00);
            ref_pc = 32'h0;
            redir_q.delete();
         end else begin
            if (bus.pc_set || bus.pc_update || bus.redirect || bus.mem_ack)
               check("ptr_ctrl", {bus.pc_set, bus.pc_update},
                     {bus.redirect, bus.mem_ack && !bus.redirect});
            if (bus.pc_set)    check("set_val", bus.pc_val, bus.redirect_pc);
            if (bus.pc_update) check("step_val", bus.pc_val, 32'd1);
            if (bus.mem_req)   check("mem_addr_is_pc", bus.mem_addr, pc_q);
            if (p_redir)       check("valid_after_redir", bus.instr_valid, 1'b0);
            if (p_valid && !p_ready && !p_redir && !p_rst)
               check("hold_stable", {bus.instr_valid, bus.instr, bus.instr_pc},
                     {1'b1, p_instr, p_ipc});
            if (bus.instr_valid && bus.instr_ready) begin
               check("xfer_pc", bus.instr_pc, ref_pc);
               check("xfer_instr", bus.instr, mem_word(ref_pc));
               ref_pc = ref_pc + 32'd1;
               xfers++;
            end
            if (bus.redirect && redir_q.size() > 0) ref_pc = redir_q.pop_front();
         end
      end
      p_valid = bus.instr_valid;
      p_ready = bus.instr_ready;
      p_redir = bus.redirect;
      p_rst   = rst;
      p_instr = bus.instr;
      p_ipc   = bus.instr_pc;
   end

   initial begin
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = 32'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b0;

      // Reset and first fetch.
      cyc(1, 0, 0, 0, 0);
      mon_en = 1'b1;
      cyc(1, 0, 0, 0, 0);
      check("rst_outputs",
            {bus.pc_set, bus.pc_update, bus.mem_req, bus.instr_valid, bus.pc_val, bus.mem_addr},
            64'h0);
      check("rst_instr", {bus.instr, bus.instr_pc}, 64'h0);
      cyc(0, 0, 0, 0, 0);
      check("idle_no_req", bus.mem_req, 1'b0);
      cyc(0, 1, 1, 0, 0);
      check("first_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0});
      check("ack_update", {bus.pc_update, bus.pc_val}, {1'b1, 32'h1});
      cyc(0, 0, 1, 0, 0);
      check("first_instr", {bus.instr_valid, bus.instr, bus.instr_pc}, {1'b1, 32'hDEADBEEF, 32'h0});

`ifndef FETCH_PREFETCH_EN
      cyc(0, 0, 0, 0, 0);
      check("next_req", {bus.instr_valid, bus.mem_req, bus.mem_addr}, {1'b0, 1'b1, 32'h1});
      // Backpressure in HOLD.
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0);
         check("bp_hold", {bus.instr_valid, bus.instr, bus.mem_req, bus.pc_update},
               {1'b1, mem_word(32'h1), 1'b0, 1'b0});
      end
      cyc(0, 0, 1, 0, 0);
      check("bp_xfer", bus.instr_valid, 1'b1);
      cyc(0, 0, 0, 0, 0);
      check("bp_resume", {bus.instr_valid, bus.mem_req, bus.mem_addr}, {1'b0, 1'b1, 32'h2});
      // Redirect during REQ without ack.
      cyc(0, 0, 0, 1, 32'h40);
      check("redir_set", {bus.pc_set, bus.pc_update, bus.pc_val}, {1'b1, 1'b0, 32'h40});
      cyc(0, 0, 0, 0, 0);
      check("redir_wait", {bus.pc_set, bus.mem_req}, 2'b00);
      cyc(0, 0, 0, 0, 0);
      check("redir_fetch", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h40});
      // Redirect colliding with an ack.
      cyc(0, 1, 1, 1, 32'h100);
      check("redir_ack_drop", {bus.pc_set, bus.pc_update}, 2'b10);
      cyc(0, 0, 1, 0, 0);
      check("redir_ack_novalid", bus.instr_valid, 1'b0);
      cyc(0, 1, 1, 0, 0);
      check("redir_ack_fetch", {bus.mem_req, bus.mem_addr, bus.pc_update}, {1'b1, 32'h100, 1'b1});
      cyc(0, 0, 1, 0, 0);
      check("redir_ack_instr", {bus.instr_valid, bus.instr_pc}, {1'b1, 32'h100});
`else
      check("pf_overlap_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h1});
      cyc(0, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 1, 0, 0);
         check("pf_stream_valid", bus.instr_valid, 1'b1);
      end
      cyc(0, 1, 1, 1, 32'h200);
      cyc(0, 0, 1, 0, 0);
      check("pf_flush_empty", bus.instr_valid, 1'b0);
      cyc(0, 1, 1, 0, 0);
      check("pf_redir_fetch", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h200});
      cyc(0, 0, 1, 0, 0);
      check("pf_redir_instr", {bus.instr_valid, bus.instr_pc}, {1'b1, 32'h200});
`endif

      // Randomized traffic, including a mid-run reset and wrap-around targets.
      for (int i = 0; i < 600; i++) begin
         bit          r, a, y, d;
         logic [31:0] t;
         r = (i >= 300 && i < 302);
         a = ($urandom % 3) != 0;
         y = ($urandom % 4) != 0;
         d = ($urandom % 20) == 0;
         t = (($urandom % 4) == 0) ? 32'hFFFFFFFD : $urandom;
         cyc(r, a, y, d, t);
      end
      cyc(0, 0, 0, 0, 0);
      check("xfer_count_min", xfers >= 60, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer end of the program-counter pointer.
- Reads the pointer's `out` value, issues an instruction read to memory, and holds the returned word for the decode stage.
- Drives the pointer's `set_enable`/`update_enable`/`val` inputs: steps the PC after each fetch and loads it on a redirect (branch/jump).
- Sits between the pointer, instruction memory and decode.

Parameters:
- WORD_SIZE, 32, data/address width; comes from parameters.v.
- PC_STEP, 1, increment driven on pc_val with pc_update (word-addressed memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  WORD_SIZE  current pointer value (pointer `out`).
- pc_val  out  WORD_SIZE  to pointer `val`: PC_STEP on update, target on set.
- pc_set  out  1  to pointer `set_enable`.
- pc_update  out  1  to pointer `update_enable`.
- mem_req  out  1  read request.
- mem_addr  out  WORD_SIZE  read address.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  WORD_SIZE  read data.
- redirect  in  1  single-cycle pulse: load redirect_pc.
- redirect_pc  in  WORD_SIZE  redirect target.
- instr  out  WORD_SIZE  fetched instruction.
- instr_pc  out  WORD_SIZE  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr.

Behaviour:
- Reset:
  - Synchronous on rst=1: state=IDLE; all outputs 0 (pc_val, instr and instr_pc cleared).
  - Reset mid-operation abandons any request. No pc_update or pc_set is issued. Held instruction is dropped.
- States: IDLE, REQ, HOLD, REDIR.
- IDLE: next cycle goes to REQ.
- REQ:
  - mem_req=1, mem_addr=pc (combinational from pc).
  - On mem_ack: capture instr=mem_rdata, instr_pc=pc; pulse pc_update=1 with pc_val=PC_STEP in that same cycle; go to HOLD.
  - Without ack: stay in REQ; mem_req stays high with a stable address.
- HOLD:
  - instr_valid=1; instr and instr_pc stable.
  - Transfer occurs when instr_valid && instr_ready; next state REQ. Valid drops the cycle after the transfer.
  - The pointer has already advanced by then, so the next fetch uses the new pc.
- Redirect (any non-IDLE state) has priority:
  - That cycle: pc_set=1, pc_val=redirect_pc, pc_update=0, instr_valid forced 0 next cycle. Any ack in the same cycle is discarded (no capture, no pc_update).
  - Next state is REDIR, which waits one cycle for the pointer to load, then goes to REQ.
  - mem_req may drop immediately. The memory holds no state across a deasserted request.
- Exclusivity: pc_set and pc_update are never high together; set wins. Each is high for exactly one cycle per event.
- Redirect in IDLE: honoured the same way (set, then REDIR).
- Redirect in REDIR: the newest target overrides, pc_set pulses again, and the block stays in REDIR.
- Wrap-around: pc increments modulo 2^WORD_SIZE inside the pointer. The fetch unit does no range check.
- Throughput without the option: at most 1 instruction per 2 cycles (zero-wait memory, instr_ready held high).

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined:
  - Adds a 2-entry instruction/pc FIFO in front of the instr outputs.
  - REQ keeps issuing while the FIFO is not full, so fetch proceeds in the same cycles that decode is accepting.
  - Sustained rate is 1 instruction/cycle with zero-wait memory and ready high.
  - Redirect flushes both entries.
  - mem_req is held low while the FIFO is full.
  - Output order is preserved.
- Undefined: single holding register, FSM as above.

Decomposition:
- WORD_SIZE and PC_STEP default go in shared parameters.v.
- FSM state encodings are localparams in parameters.v under a FETCH_ prefix.
- One sub-module, fetch_fifo (2-entry, flush input), is used only under FETCH_PREFETCH_EN.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → all outputs 0 during reset; mem_req=1 two cycles after release with mem_addr=pc=0.
- Basic fetch: pc=0, ack with rdata=32'hDEADBEEF → pc_update=1 and pc_val=1 in the ack cycle; next cycle instr=DEADBEEF, instr_pc=0, instr_valid=1; after ready, mem_addr=1.
- Backpressure: instr_ready low 5 cycles in HOLD → instr stable, mem_req=0, no pc_update; ready=1 → one transfer, mem_req returns next cycle.
- Redirect: redirect=1, redirect_pc=32'h40 during REQ without ack → pc_set=1, pc_val=40 that cycle, pc_update=0; two cycles later mem_addr=40.
- Redirect with ack: redirect and mem_ack in the same cycle → rdata discarded, no pc_update, instr_valid stays 0; fetch resumes at the target.
- Prefetch (FETCH_PREFETCH_EN): zero-wait ack, ready high, 8 instructions → 8 transfers in 8 consecutive cycles, in order; redirect mid-stream → FIFO empty next cycle.
